dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int DATA_W       = 32;
   localparam int DEF_AW_WORDS = 10;
   localparam int DEF_LATENCY  = 2;

   localparam logic [DATA_W-1:0] DMEM_BAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: synchronous write port, combinational read port
// Contents are never reset.
module dmem_array #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder (IDLE/BUSY FSM around dmem_array)
// Optional DMEM_RANGE_CHECK_EN: accesses above the storage depth return DMEM_BAD_DATA and never write.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int AW_WORDS = DEF_AW_WORDS,
   parameter int LATENCY  = DEF_LATENCY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_data_write,
   input  logic              d_write_enable,
   output logic              d_data_valid,
   output logic [DATA_W-1:0] d_data_read
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e              state_q;
   logic [3:0]          cnt_q;
   logic [DATA_W-1:0]   lat_addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                wr_q;
   logic                valid_q;

   logic                addr_chg;
   logic                start;
   logic                done;
   logic                mem_we;
   logic [AW_WORDS-1:0] idx;
   logic [DATA_W-1:0]   mem_rdata;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   wr_word;

   assign idx      = lat_addr_q[AW_WORDS+1:2];
   assign addr_chg = (d_address != lat_addr_q);

   // A pending read is abandoned whenever the address moves; a pending write always runs to completion.
   assign start = ((state_q == IDLE) && (d_write_enable || addr_chg)) ||
                  ((state_q == BUSY) && !wr_q && addr_chg);
   assign done  = (state_q == BUSY) && (cnt_q == 4'd0) && !start;

`ifdef DMEM_RANGE_CHECK_EN
   logic oob;
   assign oob     = |lat_addr_q[DATA_W-1:AW_WORDS+2];
   assign mem_we  = done && wr_q && !oob;
   assign rd_word = oob ? DMEM_BAD_DATA : mem_rdata;
   assign wr_word = oob ? DMEM_BAD_DATA : wdata_q;
`else
   assign mem_we  = done && wr_q;
   assign rd_word = mem_rdata;
   assign wr_word = wdata_q;
`endif

   dmem_array #(
      .AW (AW_WORDS),
      .DW (DATA_W)
   ) u_array (
      .clk_i   (clk),
      .we_i    (mem_we),
      .addr_i  (idx),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // Reset parks in BUSY so a read of address 0 completes on its own after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= BUSY;
         cnt_q      <= CNT_INIT;
         lat_addr_q <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         valid_q    <= 1'b0;
         rdata_q    <= '0;
      end else if (start) begin
         state_q    <= BUSY;
         cnt_q      <= CNT_INIT;
         lat_addr_q <= d_address;
         wdata_q    <= d_data_write;
         wr_q       <= d_write_enable;
         valid_q    <= 1'b0;
      end else if (state_q == BUSY) begin
         if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end else begin
            rdata_q <= wr_q ? wr_word : rd_word;
            valid_q <= 1'b1;
            state_q <= IDLE;
         end
      end
   end

   // Qualifying with the live address hides a completed word as soon as the initiator moves on.
   assign d_data_valid = valid_q && !addr_chg;
   assign d_data_read  = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY=2, AW_WORDS=10)
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] d_address = '0;
   logic [31:0] d_data_write = '0;
   logic        d_write_enable = 1'b0;
   logic        d_data_valid;
   logic [31:0] d_data_read;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .AW_WORDS (10),
      .LATENCY  (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .d_address      (d_address),
      .d_data_write   (d_data_write),
      .d_write_enable (d_write_enable),
      .d_data_valid   (d_data_valid),
      .d_data_read    (d_data_read)
   );

   // Counts rising edges (starting with the next one) until valid is seen; -1 on timeout.
   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         d_write_enable = 1'b0;
         if (d_data_valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd, output int n);
      d_address      = a;
      d_write_enable = we;
      d_data_write   = wd;
      wait_valid(n);
   endtask

   task automatic test_reset;
      int n;
      #1;
      checks++;
      if (d_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", d_data_valid); end
      checks++;
      if (d_data_read !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", d_data_read); end
      @(negedge clk);
      reset_n = 1'b1;
      wait_valid(n);
      checks++;
      if (n != 2) begin failures++; $display("FAIL reset_first_read_edges: got %0d expected 2", n); end
   endtask

   task automatic preload;
      int n;
      access(32'h0000_0000, 1'b1, 32'h1234_5678, n);
      access(32'h0000_0044, 1'b1, 32'h4444_4444, n);
      access(32'h0000_0080, 1'b1, 32'h8080_8080, n);
      access(32'h0000_0084, 1'b1, 32'h8484_8484, n);
      access(32'h0000_0020, 1'b1, 32'h2020_2020, n);
      access(32'h0000_0008, 1'b1, 32'h0808_0808, n);
   endtask

   task automatic test_reset_read;
      int n;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (d_data_read !== 32'h0) begin failures++; $display("FAIL async_reset_data: got %h expected 00000000", d_data_read); end
      d_address = 32'h0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_valid(n);
      checks++;
      if (n != 2) begin failures++; $display("FAIL post_reset_read_edges: got %0d expected 2", n); end
      checks++;
      if (d_data_read !== 32'h1234_5678) begin failures++; $display("FAIL post_reset_read_data: got %h expected 12345678", d_data_read); end
   endtask

   task automatic test_write_read;
      int n;
      access(32'h40, 1'b1, 32'hCAFE_0001, n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL wr40_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== 32'hCAFE_0001) begin failures++; $display("FAIL wr40_data: got %h expected cafe0001", d_data_read); end
      d_address = 32'h44;
      #1;
      checks++;
      if (d_data_valid !== 1'b0) begin failures++; $display("FAIL stale_valid: got %b expected 0", d_data_valid); end
      wait_valid(n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL rd44_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== 32'h4444_4444) begin failures++; $display("FAIL rd44_data: got %h expected 44444444", d_data_read); end
      access(32'h40, 1'b0, 32'h0, n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL rd40_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== 32'hCAFE_0001) begin failures++; $display("FAIL rd40_data: got %h expected cafe0001", d_data_read); end
   endtask

   task automatic test_read_abort;
      int n;
      d_address = 32'h80;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (d_data_valid !== 1'b0) begin failures++; $display("FAIL abort_busy_valid: got %b expected 0", d_data_valid); end
      d_address = 32'h84;
      wait_valid(n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL abort_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== 32'h8484_8484) begin failures++; $display("FAIL abort_data: got %h expected 84848484", d_data_read); end
      access(32'h80, 1'b0, 32'h0, n);
      checks++;
      if (d_data_read !== 32'h8080_8080) begin failures++; $display("FAIL abort_mem32: got %h expected 80808080", d_data_read); end
   endtask

   task automatic test_write_hold;
      int n;
      d_address      = 32'h10;
      d_data_write   = 32'h1010_1010;
      d_write_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_write_enable = 1'b0;
      d_address      = 32'h20;
      wait_valid(n);
      checks++;
      if (n != 5) begin failures++; $display("FAIL hold_edges: got %0d expected 5", n); end
      checks++;
      if (d_data_read !== 32'h2020_2020) begin failures++; $display("FAIL hold_rd20_data: got %h expected 20202020", d_data_read); end
      access(32'h10, 1'b0, 32'h0, n);
      checks++;
      if (d_data_read !== 32'h1010_1010) begin failures++; $display("FAIL hold_wr10_commit: got %h expected 10101010", d_data_read); end
   endtask

   task automatic test_level_write;
      int n;
      d_address      = 32'h30;
      d_data_write   = 32'hAAAA_0001;
      d_write_enable = 1'b1;
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (d_data_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n != 3) begin failures++; $display("FAIL level_first_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== 32'hAAAA_0001) begin failures++; $display("FAIL level_first_data: got %h expected aaaa0001", d_data_read); end
      d_data_write = 32'hBBBB_0002;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (d_data_valid !== 1'b0) begin failures++; $display("FAIL level_restart_valid: got %b expected 0", d_data_valid); end
      wait_valid(n);
      checks++;
      if (n != 2) begin failures++; $display("FAIL level_second_edges: got %0d expected 2", n); end
      checks++;
      if (d_data_read !== 32'hBBBB_0002) begin failures++; $display("FAIL level_second_data: got %h expected bbbb0002", d_data_read); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (d_data_valid !== 1'b1) begin failures++; $display("FAIL level_stop_valid: got %b expected 1", d_data_valid); end
   endtask

   task automatic test_reset_mid_write;
      int n;
      d_address      = 32'h8;
      d_data_write   = 32'hFFFF_FFFF;
      d_write_enable = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_write_enable = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if (d_data_read !== 32'h0) begin failures++; $display("FAIL midwr_reset_data: got %h expected 00000000", d_data_read); end
      checks++;
      if (d_data_valid !== 1'b0) begin failures++; $display("FAIL midwr_reset_valid: got %b expected 0", d_data_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      wait_valid(n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL midwr_read_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== 32'h0808_0808) begin failures++; $display("FAIL midwr_discard: got %h expected 08080808", d_data_read); end
   endtask

   task automatic test_range;
      int n;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
`ifdef DMEM_RANGE_CHECK_EN
      exp_hi = 32'hDEAD_BEEF;
      exp_lo = 32'h1234_5678;
`else
      exp_hi = 32'h5A5A_5A5A;
      exp_lo = 32'h5A5A_5A5A;
`endif
      access(32'h0001_0000, 1'b1, 32'h5A5A_5A5A, n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL range_wr_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== exp_hi) begin failures++; $display("FAIL range_wr_data: got %h expected %h", d_data_read, exp_hi); end
      access(32'h0, 1'b0, 32'h0, n);
      checks++;
      if (d_data_read !== exp_lo) begin failures++; $display("FAIL range_mem0: got %h expected %h", d_data_read, exp_lo); end
      access(32'h0001_0000, 1'b0, 32'h0, n);
      checks++;
      if (n != 3) begin failures++; $display("FAIL range_rd_edges: got %0d expected 3", n); end
      checks++;
      if (d_data_read !== exp_hi) begin failures++; $display("FAIL range_rd_data: got %h expected %h", d_data_read, exp_hi); end
   endtask

   initial begin
      test_reset();
      preload();
      test_reset_read();
      test_write_read();
      test_read_abort();
      test_write_hold();
      test_level_write();
      test_reset_mid_write();
      test_range();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
